// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// This is the operand-fetch and issue stage that sits in front of the ALU. It
// holds a small register file. Register 0 is hardwired to zero. The stage reads
// operand A from rs_a. It reads operand B from rs_b, or takes it from the
// immediate. The operands and the 2-bit operation are captured into an output
// pipeline register, and that register drives the ALU's src_a, src_b and
// ALU_Control inputs.
//
// A write-back in the same cycle bypasses into any source operand it targets.
// Flush drops the instruction that is held in the output register and blocks
// the incoming one. The register file write still happens during a flush.
//
// Ports
//   clk, reset_n            : clock and synchronous active-low reset
//   in_valid / in_ready     : upstream handshake
//   in_op                   : ALU operation code, passed through unchanged
//   in_rs_a / in_rs_b       : source register addresses
//   in_rd                   : destination tag, passed through
//   in_use_imm / in_imm     : select the immediate as operand B
//   wb_en/wb_addr/wb_data   : register file write-back port
//   flush                   : discard the held and the incoming instruction
//   src_a/src_b/ALU_Control : registered operands and operation to the ALU
//   out_rd                  : registered destination tag
//   out_valid / out_ready   : downstream handshake
// -----------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int WIDTH  = 8,
  parameter int REGS   = 4,
  parameter int ADDR_W = $clog2(REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs_a,
  input  logic [ADDR_W-1:0] in_rs_b,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_use_imm,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              flush,
  output logic [WIDTH-1:0]  src_a,
  output logic [WIDTH-1:0]  src_b,
  output logic [1:0]        ALU_Control,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [WIDTH-1:0] regs [REGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             wb_live;
  logic             accept;

  // A write to address 0 is never live. As a result, a matching source
  // address can never pull wb_data into a read of r0.
  assign wb_live  = wb_en && (wb_addr != '0);

  assign in_ready = (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Combinational operand read. The order is: r0 reads as zero first, then a
  // same-cycle bypass, then the register file contents.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch. If a
    // path left one of them unassigned, synthesis would infer a latch.
    op_a = '0;
    op_b = '0;
    if (in_rs_a != '0) begin
      if (wb_live && (wb_addr == in_rs_a)) op_a = wb_data;
      else                                 op_a = regs[in_rs_a];
    end
    if (in_use_imm) begin
      op_b = in_imm;
    end else if (in_rs_b != '0) begin
      if (wb_live && (wb_addr == in_rs_b)) op_b = wb_data;
      else                                 op_b = regs[in_rs_b];
    end
  end

  // Register file. Entry 0 is never written after reset, so it stays zero. Its
  // reads are also masked above.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the register file is reset on purpose. Architectural registers
      // must read 0 after reset. This is why the array is built from flops and
      // not from a RAM macro.
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else if (wb_live) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Output pipeline register. Flush takes priority over accept and consume.
  // Consume without replacement clears only the valid bit. The data fields
  // keep their last values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: all sequential state uses non-blocking assignments. Each flop
      // then samples pre-edge values, whatever order the blocks evaluate in.
      out_valid   <= 1'b0;
      src_a       <= '0;
      src_b       <= '0;
      ALU_Control <= 2'b00;
      out_rd      <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      src_a       <= op_a;
      src_b       <= op_b;
      ALU_Control <= in_op;
      out_rd      <= in_rd;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// Testbench for alu_operand_stage. Inputs are driven just after the falling
// edge and outputs are checked at the falling edge. A behavioural model keeps
// an array of register values and an "issued instruction" record, and the
// randomized phase compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_alu_operand_stage;

  localparam int WIDTH  = 8;
  localparam int REGS   = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_rs_a, in_rs_b, in_rd;
  logic              in_use_imm;
  logic [WIDTH-1:0]  in_imm;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;
  logic              flush;
  logic [WIDTH-1:0]  src_a, src_b;
  logic [1:0]        ALU_Control;
  logic [ADDR_W-1:0] out_rd;
  logic              out_valid;
  logic              out_ready;

  int tests = 0;
  int fails = 0;

  // Behavioural model: the register contents plus the instruction currently
  // presented to the ALU.
  logic [WIDTH-1:0]  m_regs [REGS];
  logic              m_valid;
  logic [WIDTH-1:0]  m_a, m_b;
  logic [1:0]        m_op;
  logic [ADDR_W-1:0] m_rd;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(WIDTH), .REGS(REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs_a(in_rs_a), .in_rs_b(in_rs_b), .in_rd(in_rd),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .src_a(src_a),
    .src_b(src_b), .ALU_Control(ALU_Control), .out_rd(out_rd),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  // The value a source register read should see: r0 is zero, and a live
  // same-cycle write wins over the stored value.
  function automatic logic [WIDTH-1:0] model_read(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic model_in_ready();
    return (!m_valid || out_ready) && !flush;
  endfunction

  // Advance one clock edge. The model computes its next state from the driven
  // inputs, and the DUT is then observed at the following falling edge.
  task automatic tick();
    logic             acc;
    logic [WIDTH-1:0] na, nb;
    acc = in_valid && model_in_ready();
    na  = model_read(in_rs_a);
    nb  = in_use_imm ? in_imm : model_read(in_rs_b);
    @(posedge clk);
    if (!reset_n) begin
      m_valid = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
      for (int i = 0; i < REGS; i++) m_regs[i] = '0;
    end else begin
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_a = na; m_b = nb; m_op = in_op; m_rd = in_rd;
      end else if (m_valid && out_ready) m_valid = 0;
      if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_rs_a = 0; in_rs_b = 0; in_rd = 0;
    in_use_imm = 0; in_imm = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [ADDR_W-1:0] ra,
                       input logic [ADDR_W-1:0] rb, input logic [ADDR_W-1:0] rd);
    in_valid = 1; in_op = op; in_rs_a = ra; in_rs_b = rb; in_rd = rd;
    in_use_imm = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); in_valid = 1; issue(2'b11, 1, 1, 3);
    wb_en = 1; wb_addr = 1; wb_data = 8'hFF;
    tick(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (src_a !== 8'h00 || src_b !== 8'h00) begin fails++; $display("FAIL reset_src got %h/%h exp 00/00", src_a, src_b); end
    tests++; if (ALU_Control !== 2'b00 || out_rd !== 2'd0) begin fails++; $display("FAIL reset_ctl got %b/%0d exp 00/0", ALU_Control, out_rd); end
    reset_n = 1; idle(); issue(2'b10, 3, 2, 1);
    tick();
    tests++; if (out_valid !== 1'b1 || src_a !== 8'h00 || src_b !== 8'h00) begin fails++; $display("FAIL reset_read got v=%b %h/%h exp 1 00/00", out_valid, src_a, src_b); end
    // The write to r1 made during reset must have been ignored.
    idle(); issue(2'b00, 1, 1, 0);
    tick();
    tests++; if (src_a !== 8'h00) begin fails++; $display("FAIL reset_wb_ignored got %h exp 00", src_a); end
  endtask

  task automatic test_write_read();
    idle(); wb_en = 1; wb_addr = 1; wb_data = 8'h12; tick();
    idle(); wb_en = 1; wb_addr = 2; wb_data = 8'h34; tick();
    idle(); issue(2'b01, 1, 2, 2); tick();
    tests++; if (out_valid !== 1'b1 || src_a !== 8'h12 || src_b !== 8'h34 || ALU_Control !== 2'b01 || out_rd !== 2'd2) begin
      fails++; $display("FAIL write_read got v=%b %h/%h op=%b rd=%0d exp 1 12/34 op=01 rd=2", out_valid, src_a, src_b, ALU_Control, out_rd);
    end
    // A consume with no replacement clears valid and leaves the data unchanged.
    idle(); tick();
    tests++; if (out_valid !== 1'b0 || src_a !== 8'h12 || src_b !== 8'h34) begin fails++; $display("FAIL consume_hold got v=%b %h/%h exp 0 12/34", out_valid, src_a, src_b); end
  endtask

  task automatic test_bypass_r0();
    idle(); issue(2'b10, 3, 3, 3); wb_en = 1; wb_addr = 3; wb_data = 8'hA5; tick();
    tests++; if (src_a !== 8'hA5 || src_b !== 8'hA5) begin fails++; $display("FAIL bypass got %h/%h exp A5/A5", src_a, src_b); end
    idle(); wb_en = 1; wb_addr = 0; wb_data = 8'hFF; tick();
    idle(); issue(2'b00, 0, 0, 0); tick();
    tests++; if (src_a !== 8'h00 || src_b !== 8'h00) begin fails++; $display("FAIL r0_zero got %h/%h exp 00/00", src_a, src_b); end
    // A write to r0 in the same cycle as the read must not bypass into it.
    idle(); issue(2'b00, 0, 3, 0); wb_en = 1; wb_addr = 0; wb_data = 8'hEE; tick();
    tests++; if (src_a !== 8'h00 || src_b !== 8'hA5) begin fails++; $display("FAIL r0_bypass got %h/%h exp 00/A5", src_a, src_b); end
  endtask

  task automatic test_imm();
    // A write-back to rs_b in the same cycle must not override the immediate.
    idle(); issue(2'b11, 3, 1, 1); in_use_imm = 1; in_imm = 8'h07;
    wb_en = 1; wb_addr = 1; wb_data = 8'h99; tick();
    tests++; if (src_a !== 8'hA5 || src_b !== 8'h07 || ALU_Control !== 2'b11) begin
      fails++; $display("FAIL imm got %h/%h op=%b exp A5/07 op=11", src_a, src_b, ALU_Control);
    end
  endtask

  task automatic test_stall_throughput();
    logic [WIDTH-1:0] ea [4];
    logic [WIDTH-1:0] eb [4];
    // The registers hold r1=99, r2=34, r3=A5. Load one instruction and then stall it.
    idle(); issue(2'b01, 2, 3, 1); tick();
    for (int c = 0; c < 3; c++) begin
      idle(); out_ready = 0; issue(2'b10, 1, 1, 2);
      wb_en = (c == 0); wb_addr = 2; wb_data = 8'h3C;
      #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_ready cyc%0d got %b exp 0", c, in_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || src_a !== 8'h34 || src_b !== 8'hA5 || ALU_Control !== 2'b01 || out_rd !== 2'd1) begin
        fails++; $display("FAIL stall_hold cyc%0d got v=%b %h/%h op=%b rd=%0d exp 1 34/A5 op=01 rd=1", c, out_valid, src_a, src_b, ALU_Control, out_rd);
      end
    end
    // The registers now hold r1=99, r2=3C, r3=A5. Stream four instructions.
    ea = '{8'h99, 8'h3C, 8'hA5, 8'h00};
    eb = '{8'h3C, 8'hA5, 8'h00, 8'h99};
    for (int i = 0; i < 4; i++) begin
      idle(); issue(2'(i), 2'(i + 1), 2'(i + 2), 2'(3 - i));
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready %0d got %b exp 1", i, in_ready); end
      tick();
      tests++; if (out_valid !== 1'b1 || src_a !== ea[i] || src_b !== eb[i] || ALU_Control !== 2'(i) || out_rd !== 2'(3 - i)) begin
        fails++; $display("FAIL stream %0d got v=%b %h/%h op=%b rd=%0d exp 1 %h/%h op=%0d rd=%0d", i, out_valid, src_a, src_b, ALU_Control, out_rd, ea[i], eb[i], i, 3 - i);
      end
    end
  endtask

  task automatic test_flush();
    idle(); issue(2'b10, 3, 3, 3); tick();
    idle(); out_ready = 0; issue(2'b01, 1, 1, 1); flush = 1;
    wb_en = 1; wb_addr = 2; wb_data = 8'h77;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    idle(); tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_issue got %b exp 0", out_valid); end
    idle(); issue(2'b00, 2, 0, 0); tick();
    tests++; if (src_a !== 8'h77) begin fails++; $display("FAIL flush_wb got %h exp 77", src_a); end
    // A reset while an instruction is stalled drops it completely.
    idle(); out_ready = 0; tick();
    reset_n = 0; tick(); reset_n = 1;
    tests++; if (out_valid !== 1'b0 || src_a !== 8'h00 || out_rd !== 2'd0) begin fails++; $display("FAIL reset_mid got v=%b %h rd=%0d exp 0 00 0", out_valid, src_a, out_rd); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n    = ($urandom_range(0, 49) != 0);
      in_valid   = $urandom_range(0, 3) != 0;
      in_op      = 2'($urandom);
      in_rs_a    = 2'($urandom);
      in_rs_b    = 2'($urandom);
      in_rd      = 2'($urandom);
      in_use_imm = $urandom_range(0, 3) == 0;
      in_imm     = 8'($urandom);
      wb_en      = $urandom_range(0, 1) == 1;
      wb_addr    = 2'($urandom);
      wb_data    = 8'($urandom);
      flush      = $urandom_range(0, 9) == 0;
      out_ready  = $urandom_range(0, 3) != 0;
      #1;
      tests++; if (in_ready !== model_in_ready()) begin fails++; $display("FAIL rand_ready %0d got %b exp %b", n, in_ready, model_in_ready()); end
      tick();
      tests++; if (out_valid !== m_valid || src_a !== m_a || src_b !== m_b || ALU_Control !== m_op || out_rd !== m_rd) begin
        fails++; $display("FAIL rand_out %0d got v=%b %h/%h op=%b rd=%0d exp v=%b %h/%h op=%b rd=%0d", n, out_valid, src_a, src_b, ALU_Control, out_rd, m_valid, m_a, m_b, m_op, m_rd);
      end
    end
    reset_n = 1;
  endtask

  initial begin
    m_valid = 0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0;
    for (int i = 0; i < REGS; i++) m_regs[i] = '0;
    reset_n = 0; idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass_r0();
    test_imm();
    test_stall_throughput();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch / issue stage sitting directly upstream of the ALU.
- Holds a small register file and reads two source operands, with operand B optionally replaced by an immediate.
- Registers the operands and the 2-bit operation into an output pipeline register that drives the ALU's src_a, src_b and ALU_Control inputs.
- Valid/ready handshake on both sides, write-back port with same-cycle bypass, and a flush input.

Parameters:
- WIDTH, 8, data width of registers, operands and immediate; the ALU instance uses the same value.
- REGS, 4, number of architectural registers (power of two, >= 2).
- ADDR_W, $clog2(REGS), register address width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_op  in  2  ALU operation code, passed through unchanged
- in_rs_a  in  ADDR_W  source register A
- in_rs_b  in  ADDR_W  source register B
- in_rd  in  ADDR_W  destination register tag, passed through
- in_use_imm  in  1  1 = operand B taken from in_imm
- in_imm  in  WIDTH  immediate operand
- wb_en  in  1  register write enable
- wb_addr  in  ADDR_W  write address
- wb_data  in  WIDTH  write data
- flush  in  1  discard held and incoming instruction
- src_a  out  WIDTH  registered operand A to ALU
- src_b  out  WIDTH  registered operand B to ALU
- ALU_Control  out  2  registered operation to ALU
- out_rd  out  ADDR_W  registered destination tag
- out_valid  out  1  output register holds a live instruction
- out_ready  in  1  downstream consumes this cycle

Behaviour:
- **Clocking and reset.** One clock, clk. Reset is synchronous and active-low on reset_n; all state updates on the rising edge.
- **Reset values** (reset_n=0 at an edge): out_valid=0, src_a=0, src_b=0, ALU_Control=2'b00, out_rd=0, all registers cleared to 0. Writes and accepts are ignored during a reset cycle. Reset mid-transfer drops the held instruction with no partial state.
- **Register 0** is hardwired to zero: it always reads 0 and writes to address 0 are discarded.
- **Register reads** are combinational from in_rs_a and in_rs_b.
- **Same-cycle bypass.** If wb_en=1, wb_addr!=0 and wb_addr matches a source address in the cycle an instruction is accepted, that operand takes wb_data. The register file is also written at the same edge.
- **Operand B.** operand_b = in_use_imm ? in_imm : read(in_rs_b). Bypass does not apply to operand B when in_use_imm=1.
- **in_ready** = !out_valid || out_ready (combinational). It is forced to 0 while flush=1.
- **Accept** = in_valid && in_ready && !flush. On accept, at the next edge: src_a, src_b, ALU_Control<=in_op, out_rd<=in_rd load and out_valid<=1. Latency is 1 cycle from accept to out_valid.
- **Consume without replacement.** out_valid && out_ready && !accept clears out_valid. The data registers keep their last values.
- **Stall.** out_valid && !out_ready holds all outputs stable. Held operands are not refreshed by later write-backs; hazard control lives outside this block.
- **Back-to-back.** Consume and accept in the same cycle sustain 1 instruction per cycle.
- **Flush** (flush=1): out_valid<=0 at the next edge and no accept occurs. Write-back is still performed.
- **Priority:** reset > flush > accept/consume.
- **Width rules.** No arithmetic in this block. in_imm is used at full WIDTH with no extension. Address comparisons are full ADDR_W.

Test Plan:
- **Reset.** Drive reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, src_a=src_b=0, ALU_Control=00. After release, reading rs_a=3, rs_b=2 returns 0 for both.
- **Write then read.** Write r1=8'h12 and r2=8'h34 via wb, then accept op=01, rs_a=1, rs_b=2 -> next cycle out_valid=1, src_a=12, src_b=34, ALU_Control=01.
- **Bypass and r0.** Same-cycle wb r3=8'hA5 while accepting rs_a=3, rs_b=3 -> src_a=src_b=A5. A write of r0=8'hFF followed by a read of r0 -> 0.
- **Immediate.** Accept in_use_imm=1, in_imm=8'h07, rs_b=1 (r1=12) -> src_b=07.
- **Stall and throughput.** Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 with a 4-instruction stream -> one instruction per cycle, in order.
- **Flush.** Assert flush with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the incoming instruction is not issued. A write-back in the same cycle still lands.
